// File: rtl/mbio_pkg.sv
// mbio_pkg: opcodes, FSM encoding and status layout shared by the multi-bank IO controller.
package mbio_pkg;
   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_WRITE  = 3'd1;
   localparam logic [2:0] OP_READ   = 3'd2;
   localparam logic [2:0] OP_SET    = 3'd3;
   localparam logic [2:0] OP_CLR    = 3'd4;
   localparam logic [2:0] OP_TGL    = 3'd5;
   localparam logic [2:0] OP_STATUS = 3'd6;
   localparam logic [2:0] OP_RSV    = 3'd7;
   localparam logic [7:0] ERR_RESP  = 8'hEE;
   localparam int ST_OVERRUN = 7;
   localparam int ST_TIMEOUT = 6;
   localparam int ST_BAD_CMD = 5;
   typedef enum logic [1:0] {IDLE, GET_ARG, EXEC, SEND} state_e;
   function automatic logic has_arg(input logic [2:0] op);
      return op == OP_WRITE || op == OP_SET || op == OP_CLR || op == OP_TGL;
   endfunction
endpackage

// File: rtl/io_input_sync.sv
// io_input_sync: parametrised-width 2-flop synchroniser with async active-low reset.
module io_input_sync #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] meta_q, sync_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end
   assign q_o = sync_q;
endmodule

// File: rtl/multi_bank_io_controller.sv
// multi_bank_io_controller: UART command engine driving NUM_BANKS 8-bit output banks,
// reading synchronised input banks, with argument timeout and sticky error status.
module multi_bank_io_controller
   import mbio_pkg::*;
#(
   parameter int NUM_BANKS      = 4,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int TIMER_WIDTH    = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   input  logic [NUM_BANKS*8-1:0] input_io,
   output logic [NUM_BANKS*8-1:0] output_io,
   output logic                   valid_io,
   output logic                   busy,
   output logic [7:0]             status
);
   localparam int W = NUM_BANKS * 8;
   localparam logic [5:0] NB = 6'(NUM_BANKS);
   state_e state_q, state_d;
   logic [2:0] op_q, op_d;
   logic [4:0] bank_q, bank_d, err_q, err_d;
   logic [7:0] arg_q, arg_d, tx_q, tx_d;
   logic [TIMER_WIDTH-1:0] timer_q, timer_d;
   logic [W-1:0] out_q, out_d, sync_io;
   logic bad_q, bad_d, vio_q, vio_d;
   logic ovr_q, ovr_d, tmo_q, tmo_d, badf_q, badf_d;
   logic [7:0] cur, cur_in, new_val;
   logic ovr_ev, tmo_ev, bad_ev, stat_clr;
   logic [5:0] err_sum;

   io_input_sync #(.W(W)) u_sync (.clk(clk), .rst_n(rst), .d_i(input_io), .q_o(sync_io));

   always_comb begin
      cur    = '0;
      cur_in = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (bank_q == 5'(b)) begin
            cur    = out_q[8*b +: 8];
            cur_in = sync_io[8*b +: 8];
         end
      end
   end

   assign new_val = op_q == OP_WRITE ? arg_q :
                    op_q == OP_SET   ? cur | arg_q :
                    op_q == OP_CLR   ? cur & ~arg_q : cur ^ arg_q;

   // Events landing on a STATUS-read edge survive the clear.
   assign ovr_ev   = rx_valid && (state_q == EXEC || state_q == SEND);
   assign tmo_ev   = state_q == GET_ARG && !rx_valid && timer_q == TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
   assign bad_ev   = state_q == EXEC && bad_q;
   assign stat_clr = state_q == EXEC && !bad_q && op_q == OP_STATUS;
   assign err_sum  = {1'b0, stat_clr ? 5'd0 : err_q} + 6'(ovr_ev) + 6'(tmo_ev) + 6'(bad_ev);
   assign err_d    = err_sum > 6'd31 ? 5'd31 : err_sum[4:0];
   assign ovr_d    = ovr_ev | (ovr_q & ~stat_clr);
   assign tmo_d    = tmo_ev | (tmo_q & ~stat_clr);
   assign badf_d   = bad_ev | (badf_q & ~stat_clr);

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      bank_d  = bank_q;
      bad_d   = bad_q;
      arg_d   = arg_q;
      timer_d = '0;
      out_d   = out_q;
      tx_d    = tx_q;
      vio_d   = 1'b0;
      case (state_q)
         IDLE: if (rx_valid) begin
            op_d    = rx_data[7:5];
            bank_d  = rx_data[4:0];
            bad_d   = rx_data[7:5] == OP_RSV || ({1'b0, rx_data[4:0]} >= NB &&
                      rx_data[7:5] != OP_NOP && rx_data[7:5] != OP_STATUS);
            state_d = has_arg(rx_data[7:5]) ? GET_ARG : rx_data[7:5] == OP_NOP ? IDLE : EXEC;
         end
         GET_ARG: begin
            timer_d = timer_q + 1'b1;
            if (rx_valid) begin
               arg_d   = rx_data;
               state_d = EXEC;
            end else if (tmo_ev) begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            state_d = SEND;
            tx_d    = bad_q ? ERR_RESP : op_q == OP_READ ? cur_in : op_q == OP_STATUS ? status : new_val;
            if (!bad_q && has_arg(op_q)) begin
               vio_d = new_val != cur;
               for (int b = 0; b < NUM_BANKS; b++)
                  if (bank_q == 5'(b)) out_d[8*b +: 8] = new_val;
            end
         end
         SEND: if (tx_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         op_q    <= OP_NOP;
         bank_q  <= '0;
         bad_q   <= 1'b0;
         arg_q   <= '0;
         timer_q <= '0;
         out_q   <= '0;
         tx_q    <= '0;
         vio_q   <= 1'b0;
         ovr_q   <= 1'b0;
         tmo_q   <= 1'b0;
         badf_q  <= 1'b0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         bank_q  <= bank_d;
         bad_q   <= bad_d;
         arg_q   <= arg_d;
         timer_q <= timer_d;
         out_q   <= out_d;
         tx_q    <= tx_d;
         vio_q   <= vio_d;
         ovr_q   <= ovr_d;
         tmo_q   <= tmo_d;
         badf_q  <= badf_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      status             = '0;
      status[ST_OVERRUN] = ovr_q;
      status[ST_TIMEOUT] = tmo_q;
      status[ST_BAD_CMD] = badf_q;
      status[4:0]        = err_q;
   end

   assign tx_data   = tx_q;
   assign tx_valid  = state_q == SEND;
   assign output_io = out_q;
   assign valid_io  = vio_q;
   assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_multi_bank_io_controller.sv
// tb_multi_bank_io_controller: directed commands with a scoreboard of expected
// response bytes and bank updates, checked by an independent monitor.
module tb_multi_bank_io_controller;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        tx_ready = 1'b1;
   logic [31:0] input_io = '0;
   logic [7:0]  tx_data, status;
   logic        tx_valid, valid_io, busy;
   logic [31:0] output_io;
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_tx[$];
   logic [31:0] exp_out[$];
   logic [31:0] model = '0;

   always #5 clk = ~clk;

   multi_bank_io_controller #(.NUM_BANKS(4), .TIMEOUT_CYCLES(1000), .TIMER_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .input_io(input_io), .output_io(output_io), .valid_io(valid_io),
      .busy(busy), .status(status)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst && tx_valid && tx_ready) begin
         if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected actual=%h required=none", tx_data);
         end else check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
      if (rst && valid_io) begin
         if (exp_out.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL valid_io_unexpected actual=%h required=none", output_io);
         end else check("output_io", output_io, exp_out.pop_front());
      end
   end

   task automatic send(input logic [7:0] b);
      @(posedge clk);
      #1 rx_data = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 20);
      check("idle_wait", 32'(busy), 32'd0);
   endtask

   task automatic cmd(input logic [7:0] op, input logic [7:0] arg, input bit with_arg, input logic [7:0] resp);
      exp_tx.push_back(resp);
      send(op);
      if (with_arg) send(arg);
      wait_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_output_io", output_io, 32'h0);
      check("rst_tx_data", 32'(tx_data), 32'h0);
      check("rst_tx_valid", 32'(tx_valid), 32'h0);
      check("rst_valid_io", 32'(valid_io), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_status", 32'(status), 32'h0);
      rst = 1'b1;

      model[15:8] = 8'h5A; exp_out.push_back(model);
      cmd(8'h21, 8'h5A, 1, 8'h5A);
      model[15:8] = 8'hDB; exp_out.push_back(model);
      cmd(8'h61, 8'h81, 1, 8'hDB);
      model[15:8] = 8'hD0; exp_out.push_back(model);
      cmd(8'h81, 8'h0F, 1, 8'hD0);
      model[15:8] = 8'h2F; exp_out.push_back(model);
      cmd(8'hA1, 8'hFF, 1, 8'h2F);
      model[15:8] = 8'hAF; exp_out.push_back(model);
      cmd(8'h61, 8'h81, 1, 8'hAF);
      cmd(8'h61, 8'h81, 1, 8'hAF);
      check("set_repeat_out", output_io, 32'h0000_AF00);

      input_io = 32'h00C3_0000;
      repeat (3) @(negedge clk);
      exp_tx.push_back(8'hC3);
      send(8'h42);
      @(negedge clk);
      check("read_lat_exec", 32'(tx_valid), 32'd0);
      @(negedge clk);
      check("read_lat_send", 32'(tx_valid), 32'd1);
      wait_idle();
      check("read_out_unchanged", output_io, model);

      cmd(8'h27, 8'h11, 1, 8'hEE);
      cmd(8'hE0, 8'h00, 0, 8'hEE);
      check("bad_status", 32'(status), 32'h22);
      cmd(8'hC0, 8'h00, 0, 8'h22);
      check("status_cleared", 32'(status), 32'h00);
      cmd(8'hC0, 8'h00, 0, 8'h00);

      send(8'h21);
      repeat (990) @(negedge clk);
      check("tmo_still_busy", 32'(busy), 32'd1);
      for (int n = 0; n < 50 && busy; n++) @(negedge clk);
      check("tmo_busy_drop", 32'(busy), 32'd0);
      check("tmo_status", 32'(status), 32'h41);
      model[23:16] = 8'h01; exp_out.push_back(model);
      cmd(8'h22, 8'h01, 1, 8'h01);
      cmd(8'hC0, 8'h00, 0, 8'h41);

      tx_ready = 1'b0;
      exp_tx.push_back(8'hC3);
      send(8'h42);
      repeat (2) @(negedge clk);
      check("send_hold_valid", 32'(tx_valid), 32'd1);
      check("send_hold_data", 32'(tx_data), 32'hC3);
      send(8'h21);
      @(negedge clk);
      check("overrun_status", 32'(status), 32'h81);
      check("overrun_out", output_io, model);
      @(posedge clk);
      #1 tx_ready = 1'b1;
      wait_idle();
      cmd(8'hC0, 8'h00, 0, 8'h81);

      send(8'h21);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("arst_output_io", output_io, 32'h0);
      check("arst_tx_data", 32'(tx_data), 32'h0);
      check("arst_tx_valid", 32'(tx_valid), 32'h0);
      check("arst_busy", 32'(busy), 32'h0);
      check("arst_status", 32'(status), 32'h0);
      model = '0;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      cmd(8'h42, 8'h00, 0, 8'hC3);
      cmd(8'hC0, 8'h00, 0, 8'h00);

      repeat (3) @(negedge clk);
      check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
      check("out_queue_empty", 32'(exp_out.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
